// File: rtl/fft_peak_analyzer.sv
// fft_peak_analyzer
// This block captures one 16-bin complex FFT frame per fft_valid pulse. It then
// scans the bins one per clock, computing re^2 + im^2 for each bin. When the
// scan ends it reports the index and power of the strongest bin, with a
// one-cycle done pulse. Ties keep the lower index. A new frame can be accepted
// on the same edge that processes the last bin, which gives back-to-back frames
// with no gap.
module fft_peak_analyzer #(
   parameter int DW    = 16,
   parameter int NBINS = 16,
   parameter int IDXW  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fft_valid,
   input  logic [2*DW-1:0]   fft_d0,
   input  logic [2*DW-1:0]   fft_d1,
   input  logic [2*DW-1:0]   fft_d2,
   input  logic [2*DW-1:0]   fft_d3,
   input  logic [2*DW-1:0]   fft_d4,
   input  logic [2*DW-1:0]   fft_d5,
   input  logic [2*DW-1:0]   fft_d6,
   input  logic [2*DW-1:0]   fft_d7,
   input  logic [2*DW-1:0]   fft_d8,
   input  logic [2*DW-1:0]   fft_d9,
   input  logic [2*DW-1:0]   fft_d10,
   input  logic [2*DW-1:0]   fft_d11,
   input  logic [2*DW-1:0]   fft_d12,
   input  logic [2*DW-1:0]   fft_d13,
   input  logic [2*DW-1:0]   fft_d14,
   input  logic [2*DW-1:0]   fft_d15,
   output logic              busy,
   output logic              done,
   output logic [IDXW-1:0]   freq,
   output logic [2*DW-1:0]   peak_pwr,
   output logic [15:0]       frame_cnt,
   output logic              overrun
);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t                  state;
   logic [2*DW-1:0]         frame   [NBINS];
   logic [2*DW-1:0]         in_bins [NBINS];
   logic [IDXW-1:0]         idx;
   logic [2*DW-1:0]         run_max;
   logic [IDXW-1:0]         best;

   logic [2*DW-1:0]         cur_word;
   logic signed [2*DW-1:0]  re_x;
   logic signed [2*DW-1:0]  im_x;
   logic signed [2*DW-1:0]  re_sq;
   logic signed [2*DW-1:0]  im_sq;
   logic [2*DW-1:0]         pwr;
   logic                    take;
   logic [2*DW-1:0]         win_pwr;
   logic [IDXW-1:0]         win_idx;
   logic                    last_bin;
   logic                    capture;

   // Gather the flat input bus into an indexable array for capture
   always_comb begin
      in_bins[0]  = fft_d0;
      in_bins[1]  = fft_d1;
      in_bins[2]  = fft_d2;
      in_bins[3]  = fft_d3;
      in_bins[4]  = fft_d4;
      in_bins[5]  = fft_d5;
      in_bins[6]  = fft_d6;
      in_bins[7]  = fft_d7;
      in_bins[8]  = fft_d8;
      in_bins[9]  = fft_d9;
      in_bins[10] = fft_d10;
      in_bins[11] = fft_d11;
      in_bins[12] = fft_d12;
      in_bins[13] = fft_d13;
      in_bins[14] = fft_d14;
      in_bins[15] = fft_d15;
   end

   // Power of the bin under scan plus the running-max compare
   always_comb begin
      cur_word = frame[idx];
      // Sign-extend to full width first. The low 32 bits of each product are
      // then exact, and (-32768)^2 * 2 = 2^31 still fits an unsigned 32-bit sum.
      re_x     = {{DW{cur_word[2*DW-1]}}, cur_word[2*DW-1:DW]};
      im_x     = {{DW{cur_word[DW-1]}}, cur_word[DW-1:0]};
      re_sq    = re_x * re_x;
      im_sq    = im_x * im_x;
      pwr      = re_sq + im_sq;
      take     = (idx == '0) || (pwr > run_max);
      win_pwr  = take ? pwr : run_max;
      win_idx  = take ? idx : best;
      last_bin = (state == SCAN) && (idx == IDXW'(NBINS - 1));
      capture  = fft_valid && ((state == IDLE) || last_bin);
   end

   // Scan FSM with registered result, status and counter outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         run_max   <= '0;
         best      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         freq      <= '0;
         peak_pwr  <= '0;
         frame_cnt <= '0;
         overrun   <= 1'b0;
         for (int unsigned i = 0; i < NBINS; i++) begin
            frame[i] <= '0;
         end
      end else begin
         done <= 1'b0;

         case (state)
            IDLE: begin
               busy <= 1'b0;
            end
            SCAN: begin
               run_max <= win_pwr;
               best    <= win_idx;
               idx     <= idx + 1'b1;
               if (last_bin) begin
                  freq      <= win_idx;
                  peak_pwr  <= win_pwr;
                  done      <= 1'b1;
                  frame_cnt <= frame_cnt + 16'd1;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end else if (fft_valid) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         // A capture on the last-bin edge overrides the return to IDLE and
         // restarts the scan. This keeps frames back-to-back with no gap.
         if (capture) begin
            for (int unsigned i = 0; i < NBINS; i++) begin
               frame[i] <= in_bins[i];
            end
            idx     <= '0;
            run_max <= '0;
            best    <= '0;
            state   <= SCAN;
            busy    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// tb_fft_peak_analyzer
// Directed bench with hand-computed expected frequencies and powers. It covers
// reset, a single peak, ties, the all-zero frame, signed extremes, back-to-back
// frames and overrun.
module tb_fft_peak_analyzer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fft_valid = 1'b0;
   logic [31:0] fft_d [16];
   logic        busy;
   logic        done;
   logic [3:0]  freq;
   logic [31:0] peak_pwr;
   logic [15:0] frame_cnt;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   // Schedule for run_sched: frames to drive, and the done pulses expected.
   logic [31:0] fr [3][16];
   int          drv_k [3];
   int          exp_k [3];
   int          exp_f [3];
   logic [31:0] exp_p [3];

   fft_peak_analyzer #(.DW(16), .NBINS(16), .IDXW(4)) dut (
      .clk(clk), .rst(rst), .fft_valid(fft_valid),
      .fft_d0(fft_d[0]),   .fft_d1(fft_d[1]),   .fft_d2(fft_d[2]),   .fft_d3(fft_d[3]),
      .fft_d4(fft_d[4]),   .fft_d5(fft_d[5]),   .fft_d6(fft_d[6]),   .fft_d7(fft_d[7]),
      .fft_d8(fft_d[8]),   .fft_d9(fft_d[9]),   .fft_d10(fft_d[10]), .fft_d11(fft_d[11]),
      .fft_d12(fft_d[12]), .fft_d13(fft_d[13]), .fft_d14(fft_d[14]), .fft_d15(fft_d[15]),
      .busy(busy), .done(done), .freq(freq), .peak_pwr(peak_pwr),
      .frame_cnt(frame_cnt), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic fill_frame(input int d, input logic [31:0] base, input int pk, input logic [31:0] pkval);
      for (int i = 0; i < 16; i++) fr[d][i] = (i == pk) ? pkval : base;
   endtask

   // Iteration k samples at the negedge after posedge k, then drives for posedge k+1.
   task automatic run_sched(input string tag, input int n_drv, input int n_exp, input int len,
                            input logic exp_ovr);
      int          seen;
      int          got_k [3];
      int          got_f [3];
      logic [31:0] got_p [3];
      logic        busy_cap;
      seen = 0;
      busy_cap = 1'bx;
      for (int i = 0; i < 3; i++) begin
         got_k[i] = -1; got_f[i] = -1; got_p[i] = 32'hxxxx_xxxx;
      end
      for (int k = 0; k <= len; k++) begin
         @(negedge clk);
         if (done) begin
            if (seen < 3) begin
               got_k[seen] = k; got_f[seen] = int'(freq); got_p[seen] = peak_pwr;
            end
            seen++;
         end
         if (k == drv_k[0] + 1) busy_cap = busy;
         fft_valid = 1'b0;
         for (int d = 0; d < n_drv; d++) begin
            if (drv_k[d] == k) begin
               fft_d = fr[d];
               fft_valid = 1'b1;
            end
         end
      end
      fft_valid = 1'b0;
      exp_cnt += n_exp;
      check({tag, " done count"}, seen, n_exp);
      for (int i = 0; i < n_exp; i++) begin
         check($sformatf("%s done%0d cycle", tag, i), got_k[i], exp_k[i]);
         check($sformatf("%s done%0d freq", tag, i), got_f[i], exp_f[i]);
         check($sformatf("%s done%0d peak_pwr", tag, i), got_p[i], exp_p[i]);
      end
      check({tag, " busy after capture"}, {31'd0, busy_cap}, 32'd1);
      check({tag, " busy at end"}, {31'd0, busy}, 32'd0);
      check({tag, " frame_cnt"}, {16'd0, frame_cnt}, exp_cnt);
      check({tag, " overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
   endtask

   initial begin
      int ndone;
      for (int i = 0; i < 16; i++) fft_d[i] = '0;
      drv_k = '{0, 0, 0};

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset busy",      {31'd0, busy},      32'd0);
      check("reset done",      {31'd0, done},      32'd0);
      check("reset freq",      {28'd0, freq},      32'd0);
      check("reset peak_pwr",  peak_pwr,           32'd0);
      check("reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("reset overrun",   {31'd0, overrun},   32'd0);

      // Reset mid-scan at idx=7 aborts with no done
      fill_frame(0, 32'h0001_0000, 5, 32'h0200_0100);
      @(negedge clk);
      fft_d = fr[0];
      fft_valid = 1'b1;
      @(negedge clk);
      fft_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midscan reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midscan reset no done",   ndone,              32'd0);
      check("midscan reset frame_cnt", {16'd0, frame_cnt}, 32'd0);

      // Single peak at bin 5: 512^2 + 256^2 = 0x50000
      fill_frame(0, 32'h0001_0000, 5, 32'h0200_0100);
      exp_k[0] = 17; exp_f[0] = 5; exp_p[0] = 32'h0005_0000;
      run_sched("single", 1, 1, 22, 1'b0);

      // All-zero frame
      fill_frame(0, 32'h0000_0000, 0, 32'h0000_0000);
      exp_k[0] = 17; exp_f[0] = 0; exp_p[0] = 32'h0000_0000;
      run_sched("allzero", 1, 1, 22, 1'b0);

      // Tie between bins 3 and 9 keeps the lower index
      fill_frame(0, 32'h0000_0000, 3, 32'h0100_0100);
      fr[0][9] = 32'h0100_0100;
      exp_k[0] = 17; exp_f[0] = 3; exp_p[0] = 32'h0002_0000;
      run_sched("tie", 1, 1, 22, 1'b0);

      // Extremes: (-32768,-32768) gives 2^31 and beats 32767^2 = 0x3FFF0001
      fill_frame(0, 32'h7FFF_0000, 15, 32'h8000_8000);
      exp_k[0] = 17; exp_f[0] = 15; exp_p[0] = 32'h8000_0000;
      run_sched("extreme", 1, 1, 22, 1'b0);

      // Back-to-back frames with peaks at 2, 11 and 0: 768^2 = 0x90000
      fill_frame(0, 32'h0001_0000, 2,  32'h0300_0000);
      fill_frame(1, 32'h0001_0000, 11, 32'h0300_0000);
      fill_frame(2, 32'h0001_0000, 0,  32'h0300_0000);
      drv_k = '{0, 16, 32};
      exp_k = '{17, 33, 49};
      exp_f = '{2, 11, 0};
      exp_p = '{32'h0009_0000, 32'h0009_0000, 32'h0009_0000};
      run_sched("b2b", 3, 3, 54, 1'b0);

      // Overrun: second valid 4 cycles later is dropped, first result survives
      fill_frame(0, 32'h0001_0000, 6, 32'h0200_0100);
      fill_frame(1, 32'h0001_0000, 9, 32'h0300_0000);
      drv_k = '{0, 4, 1000};
      exp_k[0] = 17; exp_f[0] = 6; exp_p[0] = 32'h0005_0000;
      run_sched("overrun", 2, 1, 30, 1'b1);
      repeat (5) @(negedge clk);
      check("overrun sticky", {31'd0, overrun}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_peak_analyzer.md
Name: fft_peak_analyzer

Overview:
- Receive-side consumer of the FAS FFT output interface.
- Accepts one 16-bin complex frame per `fft_valid` pulse on `fft_d0..fft_d15`, then serially computes the power of each bin (re² + im²).
- Reports the index of the strongest bin on `freq`, with a one-cycle `done` pulse.
- Sits downstream of the FFT core and supplies the analysis result that the bench checks against the expected frequency.

Parameters:
- DW, 16, width of each real/imag component; signed, 8 integer + 8 fraction.
- NBINS, 16, bins per frame; fixed at 16, matching the 16-wide `fft_d` bus.
- IDXW, 4, width of the bin index, equal to log2(NBINS).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- fft_valid  in  1  one-cycle pulse; `fft_d0..fft_d15` valid this cycle
- fft_d0 .. fft_d15  in  32 each  bin k: [31:16] real, [15:0] imag, two's complement
- busy  out  1  high while a frame is being scanned
- done  out  1  one-cycle pulse; `freq`/`peak_pwr` valid
- freq  out  4  index of the maximum-power bin
- peak_pwr  out  32  unsigned power of the winning bin
- frame_cnt  out  16  number of frames completed, wrapping
- overrun  out  1  sticky; set when a frame is dropped

Behaviour:
- Reset (async, `rst`=1): state IDLE; `busy`=0, `done`=0, `freq`=0, `peak_pwr`=0, `frame_cnt`=0, `overrun`=0; frame register, idx and running max cleared. Reset mid-scan aborts the frame with no `done`.
- States: IDLE, SCAN.
- Capture:
  - On a rising edge with `fft_valid`=1 and (state IDLE, or state SCAN with idx=15), all 16 words are registered.
  - idx←0, running max←0, best←0, state→SCAN.
- SCAN, each edge:
  - Compute p = re[idx]² + im[idx]², from signed 16×16 products, summed to 32-bit unsigned. Max p = 2^31 at (-32768,-32768); it must not overflow.
  - If idx=0 or p > max (strict): max←p, best←idx. Ties keep the lower index.
  - Then idx←idx+1.
- End of scan, at the edge processing idx=15:
  - The final compare is included; `freq`←winning index, `peak_pwr`←winning p, `done`←1 for exactly one cycle, `frame_cnt`←+1.
  - State→IDLE, unless `fft_valid` is high at that same edge; then capture proceeds and state stays SCAN (back-to-back with no gap).
- Latency: capture at edge T → `done` high from edge T+16 to edge T+17. Sustained throughput is one frame per 16 cycles.
- `busy` is 1 whenever state=SCAN.
- `fft_valid` while in SCAN with idx≠15: the frame is ignored and `overrun`←1 (sticky until reset). The current scan is unaffected.
- `freq`/`peak_pwr` hold their last value between `done` pulses.
- `done` is 0 at all other times.
- `frame_cnt` wraps from 0xFFFF to 0.

Test Plan:
- Reset: hold `rst`=1 for 3 cycles, release → all outputs 0, `busy`=0; assert `rst` mid-scan (idx=7) → `busy`=0 immediately, no `done` pulse.
- Single peak: bin 5 = 0x0200_0100, all others 0x0001_0000, `fft_valid` pulse at edge T → `done`=1 at edge T+16 only, `freq`=5, `peak_pwr`=0x0005_0000, `frame_cnt`=1.
- Tie / all-zero: all bins 0 → `freq`=0, `peak_pwr`=0; bins 3 and 9 both 0x0100_0100, others 0 → `freq`=3, `peak_pwr`=0x0002_0000.
- Extremes: bin 15 = 0x8000_8000, others 0x7FFF_0000 → `freq`=15, `peak_pwr`=0x8000_0000 (negative squaring and no overflow).
- Back-to-back: frames every 16 cycles with peaks at 2, 11, 0 → three `done` pulses 16 cycles apart, `freq`=2, 11, 0, `overrun`=0, `frame_cnt`=3.
- Overrun: a second `fft_valid` 4 cycles after the first → `overrun`=1 and stays 1; only one `done` is produced, and it carries the first frame's result.
